// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared constants and amplitude lookup for the tone generator
package note_pkg;

  // Sample amplitude per volume level (16-bit two's complement magnitudes)
  localparam logic [15:0] AMP_LV0 = 16'h0000;
  localparam logic [15:0] AMP_LV1 = 16'h0800;
  localparam logic [15:0] AMP_LV2 = 16'h1000;
  localparam logic [15:0] AMP_LV3 = 16'h2000;
  localparam logic [15:0] AMP_LV4 = 16'h3000;
  localparam logic [15:0] AMP_LV5 = 16'h4000;

  // Highest distinct volume level; anything above clamps to it
  localparam logic [2:0] VOL_MAX = 3'd5;

  // Divisors at or below this value encode a rest
  localparam int REST_DIV_MAX = 1;

  // Map a 3-bit volume onto its amplitude, clamping above VOL_MAX
  function automatic logic [15:0] amp_lut(input logic [2:0] vol);
    logic [15:0] a;
    a = AMP_LV5;
    if (vol < VOL_MAX) begin
      case (vol)
        3'd0:    a = AMP_LV0;
        3'd1:    a = AMP_LV1;
        3'd2:    a = AMP_LV2;
        3'd3:    a = AMP_LV3;
        default: a = AMP_LV4;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/note_gen_tone_channel.sv
// rtl/note_gen_tone_channel.sv - one divisor-to-square-wave channel with registered sample
module tone_channel
  import note_pkg::*;
#(
  parameter int DIV_W = 22,
  parameter int AMP_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [AMP_W-1:0] amp,
  output logic [AMP_W-1:0] audio,
  output logic             phase
);

  localparam logic [DIV_W-2:0] HCNT_ONE = 1;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-2:0] hcnt;
  logic [DIV_W-2:0] half;
  logic             silent;
  logic             restart;
  logic             wrap;

  assign half    = div[DIV_W-1:1];
  assign silent  = !en || (div <= DIV_W'(REST_DIV_MAX));
  // A new or changed divisor always starts the note fresh on the high half
  assign restart = silent || (div != div_q);
  assign wrap    = (hcnt == half - HCNT_ONE);

  // Half-period counter and phase; restart takes priority over wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      hcnt  <= '0;
      phase <= 1'b1;
    end else begin
      div_q <= div;
      if (restart) begin
        hcnt  <= '0;
        phase <= 1'b1;
      end else if (wrap) begin
        hcnt  <= '0;
        phase <= ~phase;
      end else begin
        hcnt  <= hcnt + HCNT_ONE;
      end
    end
  end

  // Sample register follows the current phase with one cycle of latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio <= '0;
    end else if (silent) begin
      audio <= '0;
    end else begin
      audio <= phase ? amp : (AMP_W'(0) - amp);
    end
  end

endmodule

// File: rtl/note_gen.sv
// rtl/note_gen.sv - stereo square-wave tone generator with shared enable and volume
module note_gen
  import note_pkg::*;
#(
  parameter int DIV_W = 22,
  parameter int AMP_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_l,
  input  logic [DIV_W-1:0] div_r,
  input  logic [2:0]       volume,
  output logic [AMP_W-1:0] audio_l,
  output logic [AMP_W-1:0] audio_r,
  output logic             phase_l,
  output logic             phase_r
);

  logic [AMP_W-1:0] amp;

  // Volume lookup is shared; a change shows up on the next sample of each channel
  assign amp = AMP_W'(amp_lut(volume));

  tone_channel #(.DIV_W(DIV_W), .AMP_W(AMP_W)) u_left (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .div   (div_l),
    .amp   (amp),
    .audio (audio_l),
    .phase (phase_l)
  );

  tone_channel #(.DIV_W(DIV_W), .AMP_W(AMP_W)) u_right (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .div   (div_r),
    .amp   (amp),
    .audio (audio_r),
    .phase (phase_r)
  );

endmodule

// File: tb/tb_note_gen.sv
// tb/tb_note_gen.sv - randomized self-checking bench for note_gen against a period model
module tb_note_gen;

  localparam int DIV_W = 22;
  localparam int AMP_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] div_r;
  logic [2:0]       volume;
  logic [AMP_W-1:0] audio_l;
  logic [AMP_W-1:0] audio_r;
  logic             phase_l;
  logic             phase_r;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per channel: cycles since note start, phase, last divisor, sample
  int          m_k   [2];
  bit          m_ph  [2];
  int          m_dq  [2];
  logic [15:0] m_aud [2];

  note_gen #(.DIV_W(DIV_W), .AMP_W(AMP_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .div_l   (div_l),
    .div_r   (div_r),
    .volume  (volume),
    .audio_l (audio_l),
    .audio_r (audio_r),
    .phase_l (phase_l),
    .phase_r (phase_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] amp_of(input int v);
    case (v)
      0:       return 16'h0000;
      1:       return 16'h0800;
      2:       return 16'h1000;
      3:       return 16'h2000;
      4:       return 16'h3000;
      default: return 16'h4000;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_k[c] = 0; m_ph[c] = 1'b1; m_dq[c] = 0; m_aud[c] = 16'h0000;
    end
  endtask

  // One clock edge of one channel: high for the first half cycles of each period
  task automatic model_step(input int c, input bit e, input int d, input int v);
    bit          silent;
    bit          rst;
    int          h;
    logic [15:0] a;
    silent = !e || d < 2;
    rst    = silent || d != m_dq[c];
    h      = d / 2;
    a      = amp_of(v);
    m_aud[c] = silent ? 16'h0000 : (m_ph[c] ? a : 16'h0000 - a);
    if (rst) begin
      m_k[c]  = 0;
      m_ph[c] = 1'b1;
    end else begin
      m_k[c]  = (m_k[c] + 1) % (2 * h);
      m_ph[c] = m_k[c] < h;
    end
    m_dq[c] = d;
  endtask

  task automatic check_outputs();
    chk("audio_l", 32'(audio_l), 32'(m_aud[0]));
    chk("audio_r", 32'(audio_r), 32'(m_aud[1]));
    chk("phase_l", 32'(phase_l), 32'(m_ph[0]));
    chk("phase_r", 32'(phase_r), 32'(m_ph[1]));
  endtask

  // Called at a negedge: check, drive the next inputs, advance the model, wait one cycle
  task automatic cycle(input bit e, input int dl, input int dr, input int v);
    check_outputs();
    en     = e;
    div_l  = DIV_W'(dl);
    div_r  = DIV_W'(dr);
    volume = 3'(v);
    model_step(0, e, dl, v);
    model_step(1, e, dr, v);
    @(negedge clk);
  endtask

  task automatic repeat_cycle(input int n, input bit e, input int dl, input int dr, input int v);
    for (int i = 0; i < n; i++) cycle(e, dl, dr, v);
  endtask

  // Reset asserted between edges must clear outputs immediately
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_audio_l", 32'(audio_l), 32'h0);
    chk("rst_audio_r", 32'(audio_r), 32'h0);
    chk("rst_phase_l", 32'(phase_l), 32'h1);
    chk("rst_phase_r", 32'(phase_r), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  int divs [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 17};

  initial begin
    int e, dl, dr, v;
    reset = 1'b1; en = 1'b0; div_l = '0; div_r = '0; volume = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Basic tone on the left, right resting
    repeat_cycle(20, 1, 8, 0, 5);
    // Rest divisors then a fresh note starting high
    repeat_cycle(6, 1, 0, 0, 5);
    repeat_cycle(6, 1, 1, 0, 5);
    repeat_cycle(10, 1, 6, 0, 5);
    // Odd divisor on the right, volume change mid-period
    repeat_cycle(9, 1, 6, 5, 2);
    repeat_cycle(6, 1, 6, 5, 7);
    // Divisor change into the low half of an 8-cycle note
    repeat_cycle(8, 1, 8, 5, 5);
    repeat_cycle(10, 1, 4, 5, 5);
    // Enable drop mid-note, then both channels restart together
    repeat_cycle(3, 0, 4, 5, 5);
    repeat_cycle(8, 1, 4, 5, 5);
    // Minimum audible divisors toggle every cycle
    repeat_cycle(6, 1, 2, 3, 3);
    // Reset in the middle of a tone
    repeat_cycle(5, 1, 10, 7, 4);
    async_reset();
    repeat_cycle(6, 1, 10, 7, 4);

    // Randomized run with occasional input changes
    e = 1; dl = 8; dr = 6; v = 5;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) dl = divs[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) dr = divs[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0)  v  = $urandom_range(0, 7);
      if ($urandom_range(0, 40) == 0) e  = !e;
      if ($urandom_range(0, 60) == 0) dl = $urandom_range(2, 40);
      cycle(e[0], dl, dr, v);
      if ($urandom_range(0, 700) == 0) async_reset();
    end
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
